// File: rtl/alu.sv
`default_nettype none
// ============================================================================
// Module   : alu
// Purpose  : 8-bit ALU for the 8085-style core. Combinational datapath with
//            the result, carry/borrow and flags registered one cycle later.
// Revision : 1.0 - initial release
// ============================================================================
module alu (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:0] opcode,
  input  logic [7:0] operand_A,
  input  logic [7:0] operand_B,
  input  logic       enable,
  input  logic       input_ready,
  input  logic       carry_in,
  input  logic       borrow_in,
  output logic [7:0] result_out,
  output logic       carry_out,
  output logic       borrow_out,
  output logic       result_ready,
  output logic       zero,
  output logic       negative,
  output logic       overflow
);

  localparam logic [4:0] c_OP_ADD  = 5'd0;
  localparam logic [4:0] c_OP_ADDC = 5'd1;
  localparam logic [4:0] c_OP_SUB  = 5'd2;
  localparam logic [4:0] c_OP_SUBB = 5'd3;
  localparam logic [4:0] c_OP_INR  = 5'd5;
  localparam logic [4:0] c_OP_DCR  = 5'd6;
  localparam logic [4:0] c_OP_AND  = 5'd8;
  localparam logic [4:0] c_OP_OR   = 5'd9;
  localparam logic [4:0] c_OP_XOR  = 5'd10;
  localparam logic [4:0] c_OP_CMA  = 5'd11;
  localparam logic [4:0] c_OP_RLC  = 5'd16;
  localparam logic [4:0] c_OP_RRC  = 5'd17;
  localparam logic [4:0] c_OP_RAL  = 5'd18;
  localparam logic [4:0] c_OP_RAR  = 5'd19;

  logic [8:0] w_add;
  logic [8:0] w_addc;
  logic [8:0] w_b_plus_borrow;
  logic [7:0] w_res;
  logic       w_carry;
  logic       w_borrow;
  logic       w_overflow;
  logic       w_accept;

  logic [7:0] r_result;
  logic       r_carry;
  logic       r_borrow;
  logic       r_ready;
  logic       r_zero;
  logic       r_negative;
  logic       r_overflow;

  assign w_add           = {1'b0, operand_A} + {1'b0, operand_B};
  assign w_addc          = w_add + {8'd0, carry_in};
  assign w_b_plus_borrow = {1'b0, operand_B} + {8'd0, borrow_in};
  assign w_accept        = enable && input_ready;

  always_comb begin
    w_res      = operand_A;
    w_carry    = carry_in;
    w_borrow   = borrow_in;
    w_overflow = 1'b0;
    case (opcode)
      c_OP_ADD: begin
        w_res      = w_add[7:0];
        w_carry    = w_add[8];
        w_borrow   = 1'b0;
        w_overflow = (operand_A[7] == operand_B[7]) && (w_add[7] != operand_A[7]);
      end
      c_OP_ADDC: begin
        w_res      = w_addc[7:0];
        w_carry    = w_addc[8];
        w_borrow   = 1'b0;
        w_overflow = (operand_A[7] == operand_B[7]) && (w_addc[7] != operand_A[7]);
      end
      c_OP_SUB: begin
        w_res      = operand_A - operand_B;
        w_carry    = 1'b0;
        w_borrow   = operand_A < operand_B;
        w_overflow = (operand_A[7] != operand_B[7]) && (w_res[7] != operand_A[7]);
      end
      c_OP_SUBB: begin
        w_res      = operand_A - operand_B - {7'd0, borrow_in};
        w_carry    = 1'b0;
        // 9-bit compare so B=0xFF with borrow_in set still borrows
        w_borrow   = {1'b0, operand_A} < w_b_plus_borrow;
        w_overflow = (operand_A[7] != operand_B[7]) && (w_res[7] != operand_A[7]);
      end
      c_OP_INR: begin
        w_res      = operand_A + 8'd1;
        w_overflow = !operand_A[7] && w_res[7];
      end
      c_OP_DCR: begin
        w_res      = operand_A - 8'd1;
        w_overflow = operand_A[7] && !w_res[7];
      end
      c_OP_AND: begin
        w_res    = operand_A & operand_B;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
      end
      c_OP_OR: begin
        w_res    = operand_A | operand_B;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
      end
      c_OP_XOR: begin
        w_res    = operand_A ^ operand_B;
        w_carry  = 1'b0;
        w_borrow = 1'b0;
      end
      c_OP_CMA: begin
        w_res = ~operand_A;
      end
      c_OP_RLC: begin
        w_res   = {operand_A[6:0], operand_A[7]};
        w_carry = operand_A[7];
      end
      c_OP_RRC: begin
        w_res   = {operand_A[0], operand_A[7:1]};
        w_carry = operand_A[0];
      end
      c_OP_RAL: begin
        w_res   = {operand_A[6:0], carry_in};
        w_carry = operand_A[7];
      end
      c_OP_RAR: begin
        w_res   = {carry_in, operand_A[7:1]};
        w_carry = operand_A[0];
      end
      default: begin
        w_res = operand_A;
      end
    endcase
  end

  // Outputs other than the ready pulse hold until the next accepted strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_result   <= 8'd0;
      r_carry    <= 1'b0;
      r_borrow   <= 1'b0;
      r_ready    <= 1'b0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_overflow <= 1'b0;
    end else if (w_accept) begin
      r_result   <= w_res;
      r_carry    <= w_carry;
      r_borrow   <= w_borrow;
      r_ready    <= 1'b1;
      r_zero     <= (w_res == 8'd0);
      r_negative <= w_res[7];
      r_overflow <= w_overflow;
    end else begin
      r_ready    <= 1'b0;
    end
  end

  assign result_out   = r_result;
  assign carry_out    = r_carry;
  assign borrow_out   = r_borrow;
  assign result_ready = r_ready;
  assign zero         = r_zero;
  assign negative     = r_negative;
  assign overflow     = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu
// Purpose  : Directed self-checking bench for alu.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu;

  logic       clk;
  logic       rst;
  logic [4:0] opcode;
  logic [7:0] operand_A;
  logic [7:0] operand_B;
  logic       enable;
  logic       input_ready;
  logic       carry_in;
  logic       borrow_in;
  logic [7:0] result_out;
  logic       carry_out;
  logic       borrow_out;
  logic       result_ready;
  logic       zero;
  logic       negative;
  logic       overflow;

  int checks   = 0;
  int failures = 0;

  alu dut (
    .clk          (clk),
    .rst          (rst),
    .opcode       (opcode),
    .operand_A    (operand_A),
    .operand_B    (operand_B),
    .enable       (enable),
    .input_ready  (input_ready),
    .carry_in     (carry_in),
    .borrow_in    (borrow_in),
    .result_out   (result_out),
    .carry_out    (carry_out),
    .borrow_out   (borrow_out),
    .result_ready (result_ready),
    .zero         (zero),
    .negative     (negative),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Flag vector order: {carry, borrow, zero, negative, overflow, result_ready}
  function automatic logic [5:0] flags();
    return {carry_out, borrow_out, zero, negative, overflow, result_ready};
  endfunction

  // One-cycle strobe; returns 1 time unit after the sampling edge.
  task automatic strobe(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input logic bi);
    @(negedge clk);
    opcode = op; operand_A = a; operand_B = b;
    carry_in = ci; borrow_in = bi;
    enable = 1'b1; input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'bx; input_ready = 1'b0;
    opcode = 5'd0; operand_A = 8'h11; operand_B = 8'h22;
    carry_in = 1'b1; borrow_in = 1'b1;
    @(posedge clk); #1;
    enable = 1'b1; input_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (result_out !== 8'h00 || flags() !== 6'b000000) begin
      failures++;
      $display("FAIL reset_with_strobe: result=%h flags=%b required result=00 flags=000000",
               result_out, flags());
    end
    input_ready = 1'b0; enable = 1'bx;
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (result_out !== 8'h00 || flags() !== 6'b000000) begin
      failures++;
      $display("FAIL reset_x_enable: result=%h flags=%b required result=00 flags=000000",
               result_out, flags());
    end
    enable = 1'b0;
  endtask

  task automatic test_add();
    strobe(5'd0, 8'd100, 8'd100, 1'b0, 1'b0);
    checks++;
    if (result_out !== 8'hC8 || flags() !== 6'b000111) begin
      failures++;
      $display("FAIL add_100_100: result=%h flags=%b required result=c8 flags=000111",
               result_out, flags());
    end
    @(posedge clk); #1;
    checks++;
    if (result_out !== 8'hC8 || flags() !== 6'b000110) begin
      failures++;
      $display("FAIL add_pulse_hold: result=%h flags=%b required result=c8 flags=000110",
               result_out, flags());
    end
    strobe(5'd0, 8'h80, 8'h80, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'h00 || flags() !== 6'b101011) begin
      failures++;
      $display("FAIL add_80_80: result=%h flags=%b required result=00 flags=101011",
               result_out, flags());
    end
  endtask

  task automatic test_addc_sub();
    strobe(5'd1, 8'hFF, 8'h01, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'h01 || flags() !== 6'b100001) begin
      failures++;
      $display("FAIL addc_ff_01: result=%h flags=%b required result=01 flags=100001",
               result_out, flags());
    end
    strobe(5'd2, 8'd5, 8'd7, 1'b1, 1'b0);
    checks++;
    if (result_out !== 8'hFE || flags() !== 6'b010101) begin
      failures++;
      $display("FAIL sub_5_7: result=%h flags=%b required result=fe flags=010101",
               result_out, flags());
    end
    strobe(5'd3, 8'h10, 8'h10, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'hFF || flags() !== 6'b010101) begin
      failures++;
      $display("FAIL subb_10_10_b1: result=%h flags=%b required result=ff flags=010101",
               result_out, flags());
    end
    strobe(5'd2, 8'h80, 8'h01, 1'b0, 1'b0);
    checks++;
    if (result_out !== 8'h7F || flags() !== 6'b000011) begin
      failures++;
      $display("FAIL sub_80_01_ovf: result=%h flags=%b required result=7f flags=000011",
               result_out, flags());
    end
  endtask

  task automatic test_logic();
    strobe(5'd8, 8'hF0, 8'h3C, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'h30 || flags() !== 6'b000001) begin
      failures++;
      $display("FAIL and_f0_3c: result=%h flags=%b required result=30 flags=000001",
               result_out, flags());
    end
    strobe(5'd9, 8'hF0, 8'h3C, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'hFC || flags() !== 6'b000101) begin
      failures++;
      $display("FAIL or_f0_3c: result=%h flags=%b required result=fc flags=000101",
               result_out, flags());
    end
    strobe(5'd10, 8'hFF, 8'hFF, 1'b0, 1'b0);
    checks++;
    if (result_out !== 8'h00 || flags() !== 6'b001001) begin
      failures++;
      $display("FAIL xor_ff_ff: result=%h flags=%b required result=00 flags=001001",
               result_out, flags());
    end
    strobe(5'd11, 8'h55, 8'h00, 1'b1, 1'b0);
    checks++;
    if (result_out !== 8'hAA || flags() !== 6'b100101) begin
      failures++;
      $display("FAIL cma_55: result=%h flags=%b required result=aa flags=100101",
               result_out, flags());
    end
  endtask

  task automatic test_rotate();
    logic [7:0] exp_res [4];
    logic [5:0] exp_flg [4];
    exp_res = '{8'h03, 8'hC0, 8'h02, 8'h40};
    exp_flg = '{6'b100001, 6'b100101, 6'b100001, 6'b100001};
    for (int i = 0; i < 4; i++) begin
      strobe(5'd16 + 5'(i), 8'h81, 8'h00, 1'b0, 1'b0);
      checks++;
      if (result_out !== exp_res[i] || flags() !== exp_flg[i]) begin
        failures++;
        $display("FAIL rotate_op%0d: result=%h flags=%b required result=%h flags=%b",
                 16 + i, result_out, flags(), exp_res[i], exp_flg[i]);
      end
    end
  endtask

  task automatic test_inr_dcr();
    strobe(5'd5, 8'h7F, 8'h00, 1'b0, 1'b1);
    checks++;
    if (result_out !== 8'h80 || flags() !== 6'b010111) begin
      failures++;
      $display("FAIL inr_7f: result=%h flags=%b required result=80 flags=010111",
               result_out, flags());
    end
    strobe(5'd6, 8'h00, 8'h00, 1'b1, 1'b0);
    checks++;
    if (result_out !== 8'hFF || flags() !== 6'b100101) begin
      failures++;
      $display("FAIL dcr_00: result=%h flags=%b required result=ff flags=100101",
               result_out, flags());
    end
    strobe(5'd4, 8'h5A, 8'h00, 1'b1, 1'b1);
    checks++;
    if (result_out !== 8'h5A || flags() !== 6'b110001) begin
      failures++;
      $display("FAIL undefined_op4: result=%h flags=%b required result=5a flags=110001",
               result_out, flags());
    end
  endtask

  task automatic test_enable_low();
    @(negedge clk);
    opcode = 5'd0; operand_A = 8'h01; operand_B = 8'h01;
    carry_in = 1'b0; borrow_in = 1'b0;
    enable = 1'b0; input_ready = 1'b1;
    @(posedge clk); #1;
    input_ready = 1'b0;
    checks++;
    if (result_out !== 8'h5A || flags() !== 6'b110000) begin
      failures++;
      $display("FAIL enable_low: result=%h flags=%b required result=5a flags=110000",
               result_out, flags());
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] ops   [3];
    logic [7:0] as    [3];
    logic [7:0] bs    [3];
    logic [7:0] e_res [3];
    logic [5:0] e_flg [3];
    ops   = '{5'd0, 5'd2, 5'd10};
    as    = '{8'h01, 8'h03, 8'hAA};
    bs    = '{8'h02, 8'h03, 8'h0F};
    e_res = '{8'h03, 8'h00, 8'hA5};
    e_flg = '{6'b000001, 6'b001001, 6'b000101};
    @(negedge clk);
    enable = 1'b1; input_ready = 1'b1;
    carry_in = 1'b0; borrow_in = 1'b0;
    for (int i = 0; i < 3; i++) begin
      opcode = ops[i]; operand_A = as[i]; operand_B = bs[i];
      @(posedge clk); #1;
      if (i == 2) input_ready = 1'b0;
      checks++;
      if (result_out !== e_res[i] || flags() !== e_flg[i]) begin
        failures++;
        $display("FAIL back_to_back_%0d: result=%h flags=%b required result=%h flags=%b",
                 i, result_out, flags(), e_res[i], e_flg[i]);
      end
    end
    @(posedge clk); #1;
    checks++;
    if (result_out !== 8'hA5 || result_ready !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_end: result=%h ready=%b required result=a5 ready=0",
               result_out, result_ready);
    end
  endtask

  initial begin
    test_reset();
    test_add();
    test_addc_sub();
    test_logic();
    test_rotate();
    test_inr_dcr();
    test_enable_low();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
